// File: rtl/buffer_pkgs.sv
// -----------------------------------------------------------------------------
// buffer_pkgs
//   Shared types for the fetch front end.
//   FETCH_W        : instructions carried by one fetch bundle.
//   fetch_bundle_t : {pc (block base), mask (lane valid), instr (lane words)}.
//                    instr[i] holds lane i, i.e. memory bits [32i+31:32i].
// -----------------------------------------------------------------------------
package buffer_pkgs;

   localparam int FETCH_W = 2;

   typedef struct packed {
      logic [31:0]              pc;
      logic [FETCH_W-1:0]       mask;
      logic [FETCH_W-1:0][31:0] instr;
   } fetch_bundle_t;

endpackage

// File: rtl/fetch_bq.sv
// -----------------------------------------------------------------------------
// fetch_bq
//   Generic synchronous FIFO with a combinational head (no read latency).
//   Pointers carry an extra wrap bit so full and empty are distinguished
//   without a separate counter.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (empties the FIFO)
//   flush      synchronous flush (empties the FIFO)
//   push       write push_data (ignored when full)
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   head       current head entry, valid while !empty
//   empty      no entries held
//   count      entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_bq #(
   parameter type T     = logic [31:0],
   parameter int  DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  T                         push_data,
   input  logic                     pop,
   output T                         head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth
      $error("fetch_bq: DEPTH must be a power of two and at least 2");
   end

   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic        full;
   logic        do_push;
   logic        do_pop;

   T mem [DEPTH];

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   // Same slot but different lap: writer is a whole buffer ahead.
   assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                    (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
   assign count   = wr_ptr_reg - rd_ptr_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/fetch_wide.sv
// -----------------------------------------------------------------------------
// fetch_wide
//   Multi-wide fetch stage. Each cycle it may request one aligned block of
//   FETCH_W instructions from a 1-cycle-latency instruction memory, tags the
//   returning block with its base PC and a lane mask (lanes before the fetch
//   PC are off), and queues the bundle toward decode. Requests are only made
//   when the queue has room for every outstanding response, so the queue
//   never overflows. A redirect flushes the queue and discards the response
//   arriving in that cycle.
// Ports:
//   clk_i          clock
//   reset_ni       synchronous active-low reset
//   imem_req_o     memory read request this cycle
//   imem_addr_o    block index of the request
//   imem_rdata_i   block data, valid one cycle after a request
//   valid_cons_o   bundle available to decode
//   ready_cons_i   decode accepts the bundle
//   data_o         head bundle {pc, mask, instr}
//   redirect_i     redirect strobe
//   redirect_pc_i  redirect target (bits [1:0] ignored)
//   occupancy_o    bundles currently queued
// -----------------------------------------------------------------------------
module fetch_wide
   import buffer_pkgs::fetch_bundle_t;
#(
   parameter int          FETCH_W     = buffer_pkgs::FETCH_W,
   parameter int          QDEPTH      = 4,
   parameter int          IMEM_BLOCKS = 32,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   output logic                           imem_req_o,
   output logic [$clog2(IMEM_BLOCKS)-1:0] imem_addr_o,
   input  logic [FETCH_W*32-1:0]          imem_rdata_i,
   output logic                           valid_cons_o,
   input  logic                           ready_cons_i,
   output fetch_bundle_t                  data_o,
   input  logic                           redirect_i,
   input  logic [31:0]                    redirect_pc_i,
   output logic [$clog2(QDEPTH):0]        occupancy_o
);

   localparam int OFF       = 2 + $clog2(FETCH_W);
   localparam int BA        = $clog2(IMEM_BLOCKS);
   localparam int BLK_BYTES = FETCH_W * 4;
   localparam int CW        = $clog2(QDEPTH) + 1;

   if (FETCH_W != buffer_pkgs::FETCH_W) begin : g_err_fetch_w
      $error("fetch_wide: FETCH_W must equal buffer_pkgs::FETCH_W");
   end
   if (FETCH_W < 1 || FETCH_W > 4 || (FETCH_W & (FETCH_W - 1)) != 0) begin : g_err_fw_range
      $error("fetch_wide: FETCH_W must be a power of two in 1..4");
   end
   if (IMEM_BLOCKS < 2) begin : g_err_blocks
      $error("fetch_wide: IMEM_BLOCKS must be at least 2");
   end
   if ((RESET_PC & 32'(BLK_BYTES - 1)) != 32'h0) begin : g_err_reset_pc
      $error("fetch_wide: RESET_PC must be block-aligned");
   end

   logic [31:0]         pc_reg;
   logic [31:0]         rsp_base_reg;
   logic [FETCH_W-1:0]  rsp_mask_reg;
   logic                inflight_reg;
   logic                drop_reg;

   logic [31:0]         blk_base;
   logic [31:0]         pc_next;
   logic [FETCH_W-1:0]  lane_mask;
   logic [CW:0]         credit_sum;
   logic                issue;
   logic                enq;
   logic                deq;
   logic                q_empty;
   logic [CW-1:0]       q_count;
   fetch_bundle_t       enq_bundle;
   fetch_bundle_t       q_head;

   assign blk_base = pc_reg & ~32'(BLK_BYTES - 1);
   assign pc_next  = blk_base + 32'(BLK_BYTES);

   // A lane is live when its address is at or after the fetch PC. The base
   // has its offset bits clear, so OR-ing the lane offset cannot carry.
   for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane_mask
      assign lane_mask[gi] = ((blk_base | 32'(gi * 4)) >= pc_reg);
   end

   // Credits count only what is already queued plus what is in flight; a
   // dequeue happening this same cycle is deliberately not credited.
   assign credit_sum = (CW+1)'(q_count) + (CW+1)'(inflight_reg);
   assign issue      = reset_ni && !redirect_i && (credit_sum < (CW+1)'(QDEPTH));

   assign imem_req_o  = issue;
   assign imem_addr_o = pc_reg[OFF+BA-1:OFF];

   assign enq = reset_ni && inflight_reg && !drop_reg && !redirect_i;

   always_comb begin
      enq_bundle       = '0;
      enq_bundle.pc    = rsp_base_reg;
      enq_bundle.mask  = rsp_mask_reg;
      enq_bundle.instr = imem_rdata_i;
   end

   assign valid_cons_o = reset_ni && !redirect_i && !q_empty;
   assign deq          = valid_cons_o && ready_cons_i;
   assign data_o       = q_head;
   assign occupancy_o  = reset_ni ? q_count : '0;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         pc_reg       <= RESET_PC;
         inflight_reg <= 1'b0;
         drop_reg     <= 1'b0;
      end else if (redirect_i) begin
         pc_reg       <= redirect_pc_i & 32'hFFFF_FFFC;
         inflight_reg <= 1'b0;
         drop_reg     <= 1'b0;
      end else begin
         inflight_reg <= issue;
         // Kill flag for a response that must not land. A redirect already
         // suppresses issue in its own cycle and discards the response that
         // arrives with it, so nothing here needs to raise the flag.
         drop_reg     <= drop_reg;
         if (issue) pc_reg <= pc_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (issue) begin
         rsp_base_reg <= blk_base;
         rsp_mask_reg <= lane_mask;
      end
   end

   fetch_bq #(
      .T     (fetch_bundle_t),
      .DEPTH (QDEPTH)
   ) u_bq (
      .clk       (clk_i),
      .rst_n     (reset_ni),
      .flush     (redirect_i),
      .push      (enq),
      .push_data (enq_bundle),
      .pop       (deq),
      .head      (q_head),
      .empty     (q_empty),
      .count     (q_count)
   );

endmodule

// File: tb/tb_fetch_wide.sv
// -----------------------------------------------------------------------------
// tb_fetch_wide
//   Directed scenarios followed by a randomized phase, all checked every cycle
//   against a queue-based model of the fetch stage. The instruction memory is
//   a random-filled array answering the DUT's requests one cycle later.
// -----------------------------------------------------------------------------
module tb_fetch_wide;
   import buffer_pkgs::fetch_bundle_t;

   localparam int FW = 2;
   localparam int QD = 4;
   localparam int NB = 32;

   logic          clk = 1'b0;
   logic          reset_ni;
   logic          imem_req_o;
   logic [4:0]    imem_addr_o;
   logic [FW*32-1:0] imem_rdata_i;
   logic          valid_cons_o;
   logic          ready_cons_i;
   fetch_bundle_t data_o;
   logic          redirect_i;
   logic [31:0]   redirect_pc_i;
   logic [2:0]    occupancy_o;

   always #5 clk = ~clk;

   fetch_wide #(
      .FETCH_W     (FW),
      .QDEPTH      (QD),
      .IMEM_BLOCKS (NB),
      .RESET_PC    (32'h0)
   ) dut (
      .clk_i         (clk),
      .reset_ni      (reset_ni),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rdata_i  (imem_rdata_i),
      .valid_cons_o  (valid_cons_o),
      .ready_cons_i  (ready_cons_i),
      .data_o        (data_o),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .occupancy_o   (occupancy_o)
   );

   logic [31:0]   mem [NB][FW];
   int            pass_cnt  = 0;
   int            fail_cnt  = 0;
   int            total_cnt = 0;

   // Reference model: fetch PC, queued bundles, and the one pending response.
   logic [31:0]   m_pc = 32'h0;
   fetch_bundle_t m_q[$];
   bit            m_infl = 1'b0;
   fetch_bundle_t m_pend;

   bit            prev_req = 1'b0;
   logic [4:0]    prev_addr = '0;
   fetch_bundle_t dq[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance.
   task automatic step(input bit rst_n, input bit redir, input logic [31:0] rpc, input bit rdy);
      bit          e_req;
      bit          e_valid;
      logic [2:0]  e_occ;
      int          sz;
      logic [31:0] base;
      reset_ni      = rst_n;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      ready_cons_i  = rdy;
      if (prev_req) begin
         for (int i = 0; i < FW; i++) imem_rdata_i[32*i +: 32] = mem[prev_addr][i];
      end else begin
         imem_rdata_i = {$urandom(), $urandom()};
      end
      #3;
      sz      = m_q.size();
      e_req   = rst_n && !redir && ((sz + int'(m_infl)) < QD);
      e_valid = rst_n && !redir && (sz > 0);
      e_occ   = rst_n ? 3'(sz) : 3'd0;
      chk("imem_req", imem_req_o, e_req);
      if (e_req) chk("imem_addr", imem_addr_o, (m_pc / 8) % NB);
      chk("valid", valid_cons_o, e_valid);
      chk("occupancy", occupancy_o, e_occ);
      if (e_valid) chk("data", data_o, m_q[0]);
      if (rst_n && !redir && m_infl) chk("room_at_enq", occupancy_o < 3'(QD), 1);
      if (valid_cons_o && rdy) begin
         dq.push_back(data_o);
         $display("deq pc=%08h mask=%b instr1=%08h instr0=%08h",
                  data_o.pc, data_o.mask, data_o.instr[1], data_o.instr[0]);
      end
      prev_req  = imem_req_o;
      prev_addr = imem_addr_o;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_pc   = 32'h0;
         m_q.delete();
         m_infl = 1'b0;
      end else if (redir) begin
         m_pc   = rpc & 32'hFFFF_FFFC;
         m_q.delete();
         m_infl = 1'b0;
      end else begin
         if (e_valid && rdy) void'(m_q.pop_front());
         if (m_infl) m_q.push_back(m_pend);
         if (e_req) begin
            base      = m_pc - (m_pc % 8);
            m_pend.pc = base;
            for (int i = 0; i < FW; i++) begin
               m_pend.mask[i]  = ((base + 32'(4 * i)) >= m_pc);
               m_pend.instr[i] = mem[(m_pc / 8) % NB][i];
            end
            m_pc   = base + 32'd8;
            m_infl = 1'b1;
         end else begin
            m_infl = 1'b0;
         end
      end
   endtask

   initial begin
      for (int b = 0; b < NB; b++)
         for (int i = 0; i < FW; i++) mem[b][i] = $urandom();
      reset_ni      = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      ready_cons_i  = 1'b0;
      imem_rdata_i  = '0;

      // Reset held: outputs stay low.
      for (int k = 0; k < 3; k++) step(0, 0, 0, 1);

      // 1. Release reset, consumer always ready.
      dq.delete();
      for (int k = 0; k < 5; k++) step(1, 0, 0, 1);
      chk("s1_count", dq.size(), 3);
      for (int k = 0; k < 3; k++) begin
         chk("s1_pc", dq[k].pc, 32'(8 * k));
         chk("s1_mask", dq[k].mask, 2'b11);
         chk("s1_instr", dq[k].instr, {mem[k][1], mem[k][0]});
      end

      // 2. Redirect into the second lane of a block.
      dq.delete();
      step(1, 1, 32'h0000_000E, 1);
      for (int k = 0; k < 3; k++) step(1, 0, 0, 1);
      chk("s2_latency", dq.size(), 1);
      step(1, 0, 0, 1);
      chk("s2_pc0", dq[0].pc, 32'h08);
      chk("s2_mask0", dq[0].mask, 2'b10);
      chk("s2_pc1", dq[1].pc, 32'h10);
      chk("s2_mask1", dq[1].mask, 2'b11);

      // 3. Back-pressure fills the queue, then drains in order.
      step(1, 1, 32'h0, 0);
      for (int k = 0; k < 8; k++) step(1, 0, 0, 0);
      chk("s3_occ_full", occupancy_o, 3'd4);
      chk("s3_no_req", imem_req_o, 1'b0);
      dq.delete();
      for (int k = 0; k < 12; k++) step(1, 0, 0, 1);
      for (int k = 0; k < 4; k++) chk("s3_order", dq[k].pc, 32'(8 * k));

      // 4. Redirect with three queued and one response in flight.
      step(1, 1, 32'h0, 0);
      for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
      chk("s4_occ3", occupancy_o, 3'd3);
      step(1, 1, 32'h40, 0);
      chk("s4_flushed", occupancy_o, 3'd0);
      dq.delete();
      for (int k = 0; k < 4; k++) step(1, 0, 0, 1);
      chk("s4_first_pc", dq[0].pc, 32'h40);

      // 5. One-cycle reset with a full queue.
      for (int k = 0; k < 8; k++) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      reset_ni = 1'b1;
      #1;
      chk("s5_valid", valid_cons_o, 1'b0);
      chk("s5_occ", occupancy_o, 3'd0);
      dq.delete();
      for (int k = 0; k < 4; k++) step(1, 0, 0, 1);
      chk("s5_first_pc", dq[0].pc, 32'h0);

      // 6. Redirect to the last block of the address space, then wrap.
      step(1, 1, 32'hFFFF_FFF8, 1);
      redirect_i = 1'b0;
      #1;
      chk("s6_addr", imem_addr_o, 5'd31);
      dq.delete();
      for (int k = 0; k < 5; k++) step(1, 0, 0, 1);
      chk("s6_pc0", dq[0].pc, 32'hFFFF_FFF8);
      chk("s6_pc1", dq[1].pc, 32'h0);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(63) != 0), ($urandom_range(15) == 0),
              $urandom(), ($urandom_range(9) < 7));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
